// File: rtl/oddeven_pkg.sv
// Purpose : shared MODE encodings and parity helper for the odd/even sequence counter.
// Latency : n/a (constants and a combinational helper only).
// Backpressure: n/a.
package oddeven_pkg;

    // MODE encoding driven onto the counter's MODE port.
    localparam logic [1:0] MODE_EVEN = 2'b00;
    localparam logic [1:0] MODE_ODD  = 2'b01;
    localparam logic [1:0] MODE_ALL  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // True when a value whose LSB is value_lsb already has the parity the mode
    // asks for. Only the LSB matters, so the caller passes that bit alone.
    // MODE_ALL and MODE_HOLD have no parity requirement.
    function automatic logic parity_ok(input logic value_lsb, input logic [1:0] mode);
        logic ok;
        ok = 1'b1;
        case (mode)
            MODE_EVEN: ok = ~value_lsb;
            MODE_ODD:  ok = value_lsb;
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/oddeven_step.sv
// Purpose : next-value and wrap computation for one counting step.
// Latency : combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   cur  : current count (WIDTH bits)
//   mode : MODE encoding from oddeven_pkg
//   up   : 1 = add step, 0 = subtract step
//   nxt  : next count, modulo 2^WIDTH
//   wrap : carry out (up) or borrow out (down) of the WIDTH-bit range
module oddeven_step
    import oddeven_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [1:0]       mode,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap
);

    localparam logic [WIDTH:0] STEP_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_TWO = (WIDTH+1)'(2);

    logic [WIDTH:0] step;
    logic [WIDTH:0] sum;

    always_comb begin
        step = '0;
        sum  = '0;

        // Even/odd modes step by 2 once aligned; a mismatched parity (after a
        // load or mode change) takes a single step of 1 to land on the
        // requested parity. Hold yields step 0 and so never wraps.
        if (mode == MODE_ALL) begin
            step = STEP_ONE;
        end else if (mode != MODE_HOLD) begin
            step = parity_ok(cur[0], mode) ? STEP_TWO : STEP_ONE;
        end

        // One extra bit so the MSB captures carry (up) or borrow (down).
        if (up) begin
            sum = {1'b0, cur} + step;
        end else begin
            sum = {1'b0, cur} - step;
        end

        nxt  = sum[WIDTH-1:0];
        wrap = sum[WIDTH];
    end

endmodule

// File: rtl/oddeven_counter_n.sv
// Purpose : parametrised even/odd/all up/down sequence counter with load, wrap pulse and wrap count.
// Latency : 1 cycle from any input to OUT/TC/WRAPS; all outputs are flops.
// Backpressure: none; the counter accepts its controls every cycle.
//
// Ports:
//   CLK   : clock, all state on rising edge
//   RST   : synchronous active-high reset
//   EN    : count enable
//   MODE  : 00 even, 01 odd, 10 all, 11 hold
//   UP    : 1 = count up, 0 = count down
//   LOAD  : synchronous parallel load of DIN (beats EN/MODE)
//   DIN   : load value
//   OUT   : current count
//   TC    : high for the one cycle OUT shows a post-wrap value
//   WRAPS : saturating number of wraps since reset
module oddeven_counter_n
    import oddeven_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic              UP,
    input  logic              LOAD,
    input  logic [WIDTH-1:0]  DIN,
    output logic [WIDTH-1:0]  OUT,
    output logic              TC,
    output logic [WRAP_W-1:0] WRAPS
);

    localparam logic [WRAP_W-1:0] WRAPS_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAPS_INC = WRAP_W'(1);

    logic [WIDTH-1:0]  out_q;
    logic              tc_q;
    logic [WRAP_W-1:0] wraps_q;

    logic [WIDTH-1:0]  step_nxt;
    logic              step_wrap;
    logic              counting;

    oddeven_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .cur  (out_q),
        .mode (MODE),
        .up   (UP),
        .nxt  (step_nxt),
        .wrap (step_wrap)
    );

    assign counting = EN && (MODE != MODE_HOLD);

    // Priority: RST > LOAD > counting > hold. TC only ever follows a
    // wrapping count step; load and hold both clear it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            tc_q    <= 1'b0;
            wraps_q <= '0;
        end else if (LOAD) begin
            out_q <= DIN;
            tc_q  <= 1'b0;
        end else if (counting) begin
            out_q <= step_nxt;
            tc_q  <= step_wrap;
            if (step_wrap && (wraps_q != WRAPS_MAX)) begin
                wraps_q <= wraps_q + WRAPS_INC;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign OUT   = out_q;
    assign TC    = tc_q;
    assign WRAPS = wraps_q;

endmodule

// File: tb/tb_oddeven_counter_n.sv
module tb_oddeven_counter_n;

    localparam int WIDTH  = 3;
    localparam int WRAP_W = 2;

    logic              CLK;
    logic              RST;
    logic              EN;
    logic [1:0]        MODE;
    logic              UP;
    logic              LOAD;
    logic [WIDTH-1:0]  DIN;
    logic [WIDTH-1:0]  OUT;
    logic              TC;
    logic [WRAP_W-1:0] WRAPS;

    int checks;
    int errors;

    oddeven_counter_n #(
        .WIDTH  (WIDTH),
        .WRAP_W (WRAP_W)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .EN    (EN),
        .MODE  (MODE),
        .UP    (UP),
        .LOAD  (LOAD),
        .DIN   (DIN),
        .OUT   (OUT),
        .TC    (TC),
        .WRAPS (WRAPS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; MODE = 2'b00; UP = 1'b1; LOAD = 1'b0; DIN = '0;
        tick();
        tick();
        checks++;
        if (OUT !== 3'd0 || TC !== 1'b0 || WRAPS !== 2'd0) begin
            errors++;
            $display("FAIL reset: OUT=%0d TC=%0b WRAPS=%0d, want 0 0 0", OUT, TC, WRAPS);
        end
        RST = 1'b0;
    endtask

    task automatic test_even_up();
        logic [2:0] exp_out [4] = '{3'd2, 3'd4, 3'd6, 3'd0};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        EN = 1'b1; MODE = 2'b00; UP = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (OUT !== exp_out[i] || TC !== exp_tc[i]) begin
                errors++;
                $display("FAIL even_up[%0d]: OUT=%0d TC=%0b, want %0d %0b", i, OUT, TC, exp_out[i], exp_tc[i]);
            end
        end
        checks++;
        if (WRAPS !== 2'd1) begin
            errors++;
            $display("FAIL even_up_wraps: WRAPS=%0d, want 1", WRAPS);
        end
    endtask

    task automatic test_odd_up_align();
        logic [2:0] exp_out [5] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd1};
        logic       exp_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        MODE = 2'b01; UP = 1'b1; EN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (OUT !== exp_out[i] || TC !== exp_tc[i]) begin
                errors++;
                $display("FAIL odd_up[%0d]: OUT=%0d TC=%0b, want %0d %0b", i, OUT, TC, exp_out[i], exp_tc[i]);
            end
        end
        checks++;
        if (WRAPS !== 2'd2) begin
            errors++;
            $display("FAIL odd_up_wraps: WRAPS=%0d, want 2", WRAPS);
        end
    endtask

    task automatic test_load_even_down();
        logic [2:0] exp_out [4] = '{3'd4, 3'd2, 3'd0, 3'd6};
        logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        LOAD = 1'b1; DIN = 3'd5; EN = 1'b1; MODE = 2'b00; UP = 1'b0;
        tick();
        LOAD = 1'b0;
        checks++;
        if (OUT !== 3'd5 || TC !== 1'b0) begin
            errors++;
            $display("FAIL load5: OUT=%0d TC=%0b, want 5 0", OUT, TC);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (OUT !== exp_out[i] || TC !== exp_tc[i]) begin
                errors++;
                $display("FAIL even_down[%0d]: OUT=%0d TC=%0b, want %0d %0b", i, OUT, TC, exp_out[i], exp_tc[i]);
            end
        end
        checks++;
        if (WRAPS !== 2'd3) begin
            errors++;
            $display("FAIL even_down_wraps: WRAPS=%0d, want 3", WRAPS);
        end
    endtask

    task automatic test_hold_and_load();
        // Load while TC is high from the previous wrap: TC must drop.
        LOAD = 1'b1; DIN = 3'd4;
        tick();
        LOAD = 1'b0;
        checks++;
        if (OUT !== 3'd4 || TC !== 1'b0 || WRAPS !== 2'd3) begin
            errors++;
            $display("FAIL load4: OUT=%0d TC=%0b WRAPS=%0d, want 4 0 3", OUT, TC, WRAPS);
        end
        EN = 1'b0; MODE = 2'b10; UP = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (OUT !== 3'd4 || TC !== 1'b0) begin
                errors++;
                $display("FAIL en_off_hold[%0d]: OUT=%0d TC=%0b, want 4 0", i, OUT, TC);
            end
        end
        EN = 1'b1; MODE = 2'b11;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (OUT !== 3'd4 || TC !== 1'b0) begin
                errors++;
                $display("FAIL mode_hold[%0d]: OUT=%0d TC=%0b, want 4 0", i, OUT, TC);
            end
        end
        EN = 1'b0; MODE = 2'b00; LOAD = 1'b1; DIN = 3'd3;
        tick();
        LOAD = 1'b0;
        checks++;
        if (OUT !== 3'd3 || TC !== 1'b0) begin
            errors++;
            $display("FAIL load_disabled: OUT=%0d TC=%0b, want 3 0", OUT, TC);
        end
    endtask

    task automatic test_boundaries();
        // Alignment up from 7 in even mode lands on 0 and counts as a wrap.
        LOAD = 1'b1; DIN = 3'd7;
        tick();
        LOAD = 1'b0; EN = 1'b1; MODE = 2'b00; UP = 1'b1;
        tick();
        checks++;
        if (OUT !== 3'd0 || TC !== 1'b1 || WRAPS !== 2'd3) begin
            errors++;
            $display("FAIL align_wrap: OUT=%0d TC=%0b WRAPS=%0d, want 0 1 3", OUT, TC, WRAPS);
        end
        // Odd down from 1 borrows to 7.
        LOAD = 1'b1; DIN = 3'd1;
        tick();
        LOAD = 1'b0; MODE = 2'b01; UP = 1'b0;
        tick();
        checks++;
        if (OUT !== 3'd7 || TC !== 1'b1) begin
            errors++;
            $display("FAIL odd_down_wrap: OUT=%0d TC=%0b, want 7 1", OUT, TC);
        end
        // Odd down alignment from an even value: 4 -> 3, no wrap.
        LOAD = 1'b1; DIN = 3'd4;
        tick();
        LOAD = 1'b0;
        tick();
        checks++;
        if (OUT !== 3'd3 || TC !== 1'b0) begin
            errors++;
            $display("FAIL odd_down_align: OUT=%0d TC=%0b, want 3 0", OUT, TC);
        end
        // All mode down from 0 wraps to 7.
        LOAD = 1'b1; DIN = 3'd0;
        tick();
        LOAD = 1'b0; MODE = 2'b10; UP = 1'b0;
        tick();
        checks++;
        if (OUT !== 3'd7 || TC !== 1'b1) begin
            errors++;
            $display("FAIL all_down_wrap: OUT=%0d TC=%0b, want 7 1", OUT, TC);
        end
        // EN dropped right after a wrap clears TC.
        EN = 1'b0;
        tick();
        checks++;
        if (OUT !== 3'd7 || TC !== 1'b0) begin
            errors++;
            $display("FAIL tc_clear_hold: OUT=%0d TC=%0b, want 7 0", OUT, TC);
        end
    endtask

    task automatic test_reset_priority();
        LOAD = 1'b1; DIN = 3'd5;
        tick();
        LOAD = 1'b0; EN = 1'b1; MODE = 2'b10; UP = 1'b1; RST = 1'b1;
        tick();
        checks++;
        if (OUT !== 3'd0 || TC !== 1'b0 || WRAPS !== 2'd0) begin
            errors++;
            $display("FAIL rst_midcount: OUT=%0d TC=%0b WRAPS=%0d, want 0 0 0", OUT, TC, WRAPS);
        end
        RST = 1'b0;
        tick();
        RST = 1'b1; LOAD = 1'b1; DIN = 3'd7;
        tick();
        checks++;
        if (OUT !== 3'd0 || TC !== 1'b0) begin
            errors++;
            $display("FAIL rst_over_load: OUT=%0d TC=%0b, want 0 0", OUT, TC);
        end
        RST = 1'b0; LOAD = 1'b0;
    endtask

    task automatic test_wrap_saturation();
        logic [2:0] exp_out;
        logic       exp_tc;
        int         exp_wraps;
        int         tc_pulses;
        RST = 1'b1; LOAD = 1'b0; EN = 1'b0;
        tick();
        RST = 1'b0; EN = 1'b1; MODE = 2'b10; UP = 1'b1;
        exp_out   = 3'd0;
        exp_wraps = 0;
        tc_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            exp_tc  = (exp_out == 3'd7);
            exp_out = exp_out + 3'd1;
            if (exp_tc && exp_wraps < 3) exp_wraps++;
            tick();
            if (TC === 1'b1) tc_pulses++;
            checks++;
            if (OUT !== exp_out || TC !== exp_tc || WRAPS !== exp_wraps[1:0]) begin
                errors++;
                $display("FAIL sat_edge[%0d]: OUT=%0d TC=%0b WRAPS=%0d, want %0d %0b %0d",
                         i, OUT, TC, WRAPS, exp_out, exp_tc, exp_wraps);
            end
        end
        checks++;
        if (tc_pulses != 5) begin
            errors++;
            $display("FAIL sat_tc_count: pulses=%0d, want 5", tc_pulses);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1; EN = 1'b0; MODE = 2'b00; UP = 1'b1; LOAD = 1'b0; DIN = '0;
        test_reset();
        test_even_up();
        test_odd_up_align();
        test_load_even_down();
        test_hold_and_load();
        test_boundaries();
        test_reset_priority();
        test_wrap_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oddeven_counter_n.md
Name: oddeven_counter_n

Overview:
- Parametrised successor to the fixed 3-bit odd/even sequence counter.
- Counts in one of four modes: even values, odd values, all values, or hold.
- Direction (up/down) is selectable.
- Supports synchronous parallel load, a terminal-count pulse and a saturating wrap counter.
- Used as a programmable sequence source for the practice designs in the project, driving displays/decoders through the OUT bus.

Parameters:
- WIDTH, 3, counter width in bits (>=2).
- WRAP_W, 4, width of the wrap-event counter WRAPS (>=1).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  count enable.
- MODE  in  2  00 even, 01 odd, 10 all, 11 hold.
- UP  in  1  1 = count up, 0 = count down.
- LOAD  in  1  synchronous parallel load strobe.
- DIN  in  WIDTH  load value.
- OUT  out  WIDTH  current count (registered).
- TC  out  1  one-cycle pulse on wrap-around (registered).
- WRAPS  out  WRAP_W  number of wraps since reset, saturating.

Behaviour:
- Single clock CLK; reset is synchronous and active-high on RST. No asynchronous paths; all outputs come straight from flops.
- Reset values: OUT = 0, TC = 0, WRAPS = 0.
- Priority per edge: RST > LOAD > (EN and MODE != hold) > hold.
- LOAD:
  - OUT <= DIN verbatim, whatever its parity.
  - TC <= 0; WRAPS unchanged.
  - Honoured even when EN = 0 or MODE = hold.
- EN = 0 or MODE = 11: OUT holds, TC <= 0.
- Step size, when counting:
  - MODE all: step = 1.
  - MODE even/odd, OUT parity matches mode (LSB = 0 for even, 1 for odd): step = 2.
  - MODE even/odd, parity mismatched (after a mode change or load): step = 1, an alignment step that lands on the requested parity. Normal stepping by 2 follows.
- Arithmetic:
  - UP = 1: next = OUT + step; UP = 0: next = OUT - step, computed in WIDTH+1 bits.
  - OUT <= next mod 2^WIDTH.
  - Wrap = carry out (up) or borrow out (down) of the WIDTH-bit range.
  - Examples, WIDTH = 3: even up 6 -> 0; odd up 7 -> 1; even down 0 -> 6; odd down 1 -> 7; alignment up from 7 in even mode -> 0, which is a wrap.
- TC:
  - TC <= 1 for exactly the cycle after a wrapping step, i.e. TC is high while OUT shows the post-wrap value.
  - Otherwise 0; never asserted by LOAD or RST.
- WRAPS: increments by 1 on each wrapping step; saturates at 2^WRAP_W - 1; cleared only by RST.
- MODE and UP are sampled every edge. A change takes effect on the same edge it is sampled. No pipeline; latency from input to OUT is 1 cycle.
- RST mid-count aborts immediately: the next edge gives OUT = 0, TC = 0, WRAPS = 0 regardless of other inputs.

Decomposition:
- Shared package oddeven_pkg holds:
  - MODE encoding constants MODE_EVEN = 2'b00, MODE_ODD = 2'b01, MODE_ALL = 2'b10, MODE_HOLD = 2'b11.
  - Helper function parity_ok(value, mode).
- One combinational sub-module, oddeven_step. It is parametrised by WIDTH and takes OUT, MODE and UP. It returns the next value and a wrap flag.
- The top level holds the registers, priority logic, TC and WRAPS.

Test Plan:
- WIDTH = 3, RST then MODE = 00, UP = 1, EN = 1 for 5 edges -> OUT 0,2,4,6,0. TC = 1 only while OUT = 0 after 6; WRAPS = 1.
- From OUT = 0, set MODE = 01, UP = 1 -> OUT 1 (alignment), 3, 5, 7, 1. TC pulses once at 7 -> 1.
- LOAD DIN = 5, then MODE = 00, UP = 0 -> OUT 5, 4 (alignment), 2, 0, 6. TC pulses once at 0 -> 6.
- Hold and load while disabled:
  - EN = 0 for 3 edges at OUT = 4 -> OUT stays 4, TC = 0.
  - MODE = 11 with EN = 1 -> OUT holds.
  - LOAD DIN = 3 with EN = 0 -> OUT = 3 next edge.
- Reset priority:
  - RST during counting at OUT = 5 -> next edge OUT = 0, TC = 0, WRAPS = 0.
  - RST and LOAD (DIN = 7) asserted together -> OUT = 0.
- WRAP_W = 2, MODE = 10, UP = 1, 40 edges -> 5 wraps occur. WRAPS reads 1, 2, 3, 3, 3 and TC still pulses on every wrap.
